ps2_key_event: RTL
==================

# ps2_key_event

Converts the raw PS/2 scancode byte stream into clean, one-pulse-per-keystroke events for the character terminal writer. It strips make/break/extended prefixes and tracks the Shift, Ctrl and Caps Lock state. It suppresses typematic repeats on request and emits an ASCII code alongside the raw code. It sits between the PS/2 byte receiver (upstream, `ready`/`keycodeout`) and the terminal cursor/char-buffer write FSM (downstream).

## Interface
- `REPEAT_EN`, default 0: 1 = every typematic make emits an event; 0 = only the first make of a held key emits.
- `clk` input 1: system clock (`clk_50m` domain). Single clock.
- `clrn` input 1: reset, synchronous, active-low.
- `scan_valid` input 1: one-cycle strobe, `scan_data` valid.
- `scan_data` input 8: received scancode byte.
- `key_valid` output 1: one-cycle strobe, event fields valid.
- `key_code` output 8: scancode of the event key, prefixes removed.
- `key_ext` output 1: event key carried an E0 prefix.
- `key_ascii` output 8: mapped ASCII; 8'h00 if non-printable.
- `shift`, `ctrl`, `caps_lock` output 1 each: current modifier state.
- `pressing` output 1: a non-modifier key is currently held.
- `key_count` output 8: number of emitted events, wraps 8'hFF→8'h00.

## Operation
- **Reset values.** All outputs reset to 0. The FSM resets to IDLE, `last_make` (9 bits {ext, code}) resets to 0, and `skip_cnt` resets to 0.
- **FSM states:** IDLE, EXT, BRK, EXT_BRK, SKIP.
  - Any state except SKIP, byte E0 → EXT. Prefix restarts, no error.
  - IDLE, F0 → BRK. EXT, F0 → EXT_BRK. BRK/EXT_BRK, F0 → unchanged.
  - IDLE, E1 → SKIP with `skip_cnt`=7. SKIP consumes 7 bytes unconditionally (Pause sequence), then → IDLE. No event is emitted.
  - IDLE, AA/FA/EE/FE/00/FF → ignored (BAT, ack, echo, resend, errors).
  - IDLE/EXT, other byte = make of {ext, code} → IDLE.
  - BRK/EXT_BRK, other byte = break of {ext, code} → IDLE.
- **Modifiers.** Modifier makes and breaks update state only and never emit `key_valid`.
  - `shift`: set by make of 12 or 59, cleared by the break of either.
  - `ctrl`: set by make of 14 or E0 14, cleared by the break of either.
  - `caps_lock`: toggles on the first make of 58 only; repeats do not toggle.
- **Non-modifier make:**
  - Repeat = `pressing`=1 and {ext, code}==`last_make`. If repeat and `REPEAT_EN`=0, no event.
  - Otherwise: `key_valid`=1, `key_code`/`key_ext` loaded, `key_ascii` loaded from the map, `key_count`+1.
  - Every make (repeat or not) sets `pressing`=1 and `last_make`={ext, code}.
- **Non-modifier break:** clears `pressing` only if {ext, code}==`last_make`; otherwise no effect. A break never emits.
- **ASCII map:**
  - Letters: uppercase iff `shift` XOR `caps_lock`.
  - Digits and punctuation: shifted symbol iff `shift`.
  - 29 → 20, 5A → 0D, 66 → 08, 0D → 09.
  - Any E0 key, any `ctrl`-held key, and all unmapped codes → 00.

## Timing
- `key_valid` rises exactly 1 clk after the `scan_valid` of the final byte, and stays high 1 clk.
- All event outputs are registered. `key_code`, `key_ext` and `key_ascii` hold their values until the next event.
- Modifier outputs and `pressing` update 1 clk after the relevant `scan_valid`.
- The ASCII lookup uses modifier state from before the current byte.
- Back-to-back `scan_valid` on consecutive cycles must be accepted with no byte lost.
- `scan_valid` while `clrn`=0: the byte is discarded.
- Reset mid-sequence: returns to IDLE. Modifiers and `caps_lock` clear. Any partial prefix is lost.

## Structure
- Shared package `ps2_pkg`:
  - Prefix constants E0, E1, F0.
  - Modifier codes 12, 59, 14, 58.
  - Codes 5A, 66, 29, 0D.
  - FSM state typedef.
- One sub-module, `ps2_ascii_map`: combinational {code, ext, shift, caps, ctrl} → ASCII, instantiated once.

## Test plan
- Reset, then bytes 1C, F0, 1C → one `key_valid`, `key_code`=1C, `key_ascii`=61 ('a'), `key_count`=1, `pressing` 1 then 0.
- 12, 1C, F0 1C, F0 12 → `key_ascii`=41 ('A'); `shift`=1 during the event, then 0. Only 1 event emitted.
- 58 F0 58, then 1C → `caps_lock`=1, `key_ascii`=41. Then 12, 1C → `key_ascii`=61.
- `REPEAT_EN`=0: 1C ×5, F0 1C → 1 event. `REPEAT_EN`=1: same stimulus → 5 events, `key_count`=5.
- E0 75, E0 F0 75 → 1 event, `key_ext`=1, `key_code`=75, `key_ascii`=00.
- E1 14 77 E1 F0 14 F0 77 then 5A → no event for Pause. The 5A event has `key_ascii`=0D. Also check `clrn` low during F0 → state IDLE and the next 1C emits.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared scancode constants, FSM state type and lookup helpers for the PS/2 key event path.
package ps2_pkg;

  localparam logic [7:0] PFX_EXT   = 8'hE0;
  localparam logic [7:0] PFX_PAUSE = 8'hE1;
  localparam logic [7:0] PFX_BRK   = 8'hF0;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_TAB    = 8'h0D;

  // Bytes following E1 in the Pause make sequence.
  localparam logic [2:0] PAUSE_TAIL = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK,
    SKIP
  } state_t;

  // Keyboard housekeeping bytes that carry no key information.
  function automatic logic is_ignored(input logic [7:0] b);
    return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hEE) ||
           (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
  endfunction

  // Lowercase ASCII for a letter scancode, 0 when the code is not a letter.
  function automatic logic [7:0] letter_lc(input logic [7:0] code);
    logic [7:0] lc;
    lc = 8'h00;
    case (code)
      8'h1C: lc = "a";
      8'h32: lc = "b";
      8'h21: lc = "c";
      8'h23: lc = "d";
      8'h24: lc = "e";
      8'h2B: lc = "f";
      8'h34: lc = "g";
      8'h33: lc = "h";
      8'h43: lc = "i";
      8'h3B: lc = "j";
      8'h42: lc = "k";
      8'h4B: lc = "l";
      8'h3A: lc = "m";
      8'h31: lc = "n";
      8'h44: lc = "o";
      8'h4D: lc = "p";
      8'h15: lc = "q";
      8'h2D: lc = "r";
      8'h1B: lc = "s";
      8'h2C: lc = "t";
      8'h3C: lc = "u";
      8'h2A: lc = "v";
      8'h1D: lc = "w";
      8'h22: lc = "x";
      8'h35: lc = "y";
      8'h1A: lc = "z";
      default: lc = 8'h00;
    endcase
    return lc;
  endfunction

endpackage

// File: rtl/ps2_ascii_map.sv
// Combinational scan set 2 -> ASCII translation; zero latency, no flow control.
module ps2_ascii_map
  import ps2_pkg::*;
(
  input  logic [7:0] code,
  input  logic       ext,
  input  logic       shift,
  input  logic       caps,
  input  logic       ctrl,
  output logic [7:0] ascii
);

  logic [7:0] lc;

  always_comb begin
    ascii = 8'h00;
    lc    = letter_lc(code);
    // Extended keys and control chords have no printable form.
    if (!ext && !ctrl) begin
      if (lc != 8'h00) begin
        ascii = (shift ^ caps) ? (lc - 8'h20) : lc;
      end else begin
        case (code)
          8'h16:    ascii = shift ? "!"  : "1";
          8'h1E:    ascii = shift ? "@"  : "2";
          8'h26:    ascii = shift ? "#"  : "3";
          8'h25:    ascii = shift ? "$"  : "4";
          8'h2E:    ascii = shift ? "%"  : "5";
          8'h36:    ascii = shift ? "^"  : "6";
          8'h3D:    ascii = shift ? "&"  : "7";
          8'h3E:    ascii = shift ? "*"  : "8";
          8'h46:    ascii = shift ? "("  : "9";
          8'h45:    ascii = shift ? ")"  : "0";
          8'h0E:    ascii = shift ? "~"  : 8'h60;
          8'h4E:    ascii = shift ? "_"  : "-";
          8'h55:    ascii = shift ? "+"  : "=";
          8'h54:    ascii = shift ? "{"  : "[";
          8'h5B:    ascii = shift ? "}"  : "]";
          8'h5D:    ascii = shift ? "|"  : "\\";
          8'h4C:    ascii = shift ? ":"  : ";";
          8'h52:    ascii = shift ? 8'h22 : 8'h27;
          8'h41:    ascii = shift ? "<"  : ",";
          8'h49:    ascii = shift ? ">"  : ".";
          8'h4A:    ascii = shift ? "?"  : "/";
          SC_SPACE: ascii = 8'h20;
          SC_ENTER: ascii = 8'h0D;
          SC_BKSP:  ascii = 8'h08;
          SC_TAB:   ascii = 8'h09;
          default:  ascii = 8'h00;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_key_event.sv
// PS/2 scancode stream -> one-pulse key events with modifier tracking and ASCII.
// Event outputs registered, 1 clk after the final byte; accepts a byte every cycle, no backpressure.
module ps2_key_event
  import ps2_pkg::*;
#(
  parameter bit REPEAT_EN = 1'b0
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       scan_valid,
  input  logic [7:0] scan_data,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic [7:0] key_ascii,
  output logic       shift,
  output logic       ctrl,
  output logic       caps_lock,
  output logic       pressing,
  output logic [7:0] key_count
);

  state_t     state_q, state_d;
  logic [2:0] skip_cnt_q, skip_cnt_d;
  logic [8:0] last_make_q, last_make_d;
  logic       pressing_q, pressing_d;
  logic       shift_q, shift_d;
  logic       ctrl_q, ctrl_d;
  logic       caps_q, caps_d;
  logic       caps_held_q, caps_held_d;
  logic       key_valid_q, key_valid_d;
  logic [7:0] key_code_q, key_code_d;
  logic       key_ext_q, key_ext_d;
  logic [7:0] key_ascii_q, key_ascii_d;
  logic [7:0] key_count_q, key_count_d;

  logic       ev_ext;
  logic       ev_brk;
  logic [8:0] ev_key;
  logic       is_shift;
  logic       is_ctrl;
  logic       is_caps;
  logic       is_repeat;
  logic [7:0] map_ascii;

  assign ev_ext    = (state_q == EXT) || (state_q == EXT_BRK);
  assign ev_brk    = (state_q == BRK) || (state_q == EXT_BRK);
  assign ev_key    = {ev_ext, scan_data};
  assign is_shift  = !ev_ext && ((scan_data == SC_LSHIFT) || (scan_data == SC_RSHIFT));
  assign is_ctrl   = (scan_data == SC_CTRL);
  assign is_caps   = !ev_ext && (scan_data == SC_CAPS);
  assign is_repeat = pressing_q && (ev_key == last_make_q);

  // Lookup sees modifier state from before the current byte.
  ps2_ascii_map u_ascii_map (
    .code  (scan_data),
    .ext   (ev_ext),
    .shift (shift_q),
    .caps  (caps_q),
    .ctrl  (ctrl_q),
    .ascii (map_ascii)
  );

  always_comb begin
    state_d     = state_q;
    skip_cnt_d  = skip_cnt_q;
    last_make_d = last_make_q;
    pressing_d  = pressing_q;
    shift_d     = shift_q;
    ctrl_d      = ctrl_q;
    caps_d      = caps_q;
    caps_held_d = caps_held_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    key_ext_d   = key_ext_q;
    key_ascii_d = key_ascii_q;
    key_count_d = key_count_q;

    if (scan_valid) begin
      if (state_q == SKIP) begin
        skip_cnt_d = skip_cnt_q - 3'd1;
        if (skip_cnt_q == 3'd1) state_d = IDLE;
      end else if (scan_data == PFX_EXT) begin
        state_d = EXT;
      end else if (scan_data == PFX_BRK) begin
        if (state_q == IDLE)     state_d = BRK;
        else if (state_q == EXT) state_d = EXT_BRK;
      end else if ((state_q == IDLE) && (scan_data == PFX_PAUSE)) begin
        state_d    = SKIP;
        skip_cnt_d = PAUSE_TAIL;
      end else if ((state_q == IDLE) && is_ignored(scan_data)) begin
        state_d = IDLE;
      end else begin
        state_d = IDLE;
        if (ev_brk) begin
          if (is_shift) begin
            shift_d = 1'b0;
          end else if (is_ctrl) begin
            ctrl_d = 1'b0;
          end else if (is_caps) begin
            caps_held_d = 1'b0;
          end else if (ev_key == last_make_q) begin
            pressing_d = 1'b0;
          end
        end else begin
          if (is_shift) begin
            shift_d = 1'b1;
          end else if (is_ctrl) begin
            ctrl_d = 1'b1;
          end else if (is_caps) begin
            // Typematic repeats of Caps Lock must not toggle again.
            if (!caps_held_q) caps_d = !caps_q;
            caps_held_d = 1'b1;
          end else begin
            if (!is_repeat || REPEAT_EN) begin
              key_valid_d = 1'b1;
              key_code_d  = scan_data;
              key_ext_d   = ev_ext;
              key_ascii_d = map_ascii;
              key_count_d = key_count_q + 8'd1;
            end
            pressing_d  = 1'b1;
            last_make_d = ev_key;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q     <= IDLE;
      skip_cnt_q  <= 3'd0;
      last_make_q <= 9'd0;
      pressing_q  <= 1'b0;
      shift_q     <= 1'b0;
      ctrl_q      <= 1'b0;
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
      key_valid_q <= 1'b0;
      key_code_q  <= 8'd0;
      key_ext_q   <= 1'b0;
      key_ascii_q <= 8'd0;
      key_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      skip_cnt_q  <= skip_cnt_d;
      last_make_q <= last_make_d;
      pressing_q  <= pressing_d;
      shift_q     <= shift_d;
      ctrl_q      <= ctrl_d;
      caps_q      <= caps_d;
      caps_held_q <= caps_held_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_ext_q   <= key_ext_d;
      key_ascii_q <= key_ascii_d;
      key_count_q <= key_count_d;
    end
  end

  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_ext   = key_ext_q;
  assign key_ascii = key_ascii_q;
  assign shift     = shift_q;
  assign ctrl      = ctrl_q;
  assign caps_lock = caps_q;
  assign pressing  = pressing_q;
  assign key_count = key_count_q;

endmodule
